// File: rtl/event_display_pkg.sv
// Shared 7-segment definitions for the event counter display.
// Glyphs are active-low and ordered {CA,CB,CC,CD,CE,CF,CG}.
package event_display_pkg;

    typedef logic [6:0] seg_glyph_t;

    localparam seg_glyph_t SEG_BLANK = 7'b1111111;

    localparam seg_glyph_t SEG_GLYPHS [0:15] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    function automatic seg_glyph_t glyph_of(input logic [3:0] nibble);
        return SEG_GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Button conditioning: 2-flop synchroniser, optional debounce filter
// (enabled by defining DEBOUNCE_EN), and a one-cycle rising-edge pulse.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    logic       r_sync0;
    logic       r_sync1;
    logic       r_prev;
    logic       r_armed;
    logic [1:0] r_valid;
    logic       w_level;

    // r_valid marks when r_sync1 holds a real post-reset sample, so a press
    // held through reset cannot arm the edge detector.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_valid <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync0 <= i_btn;
            r_sync1 <= r_sync0;
            r_valid <= {r_valid[0], 1'b1};
            if (r_valid[1] && !r_sync1) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_db_cnt;
    logic             r_db_level;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
        end else if (r_sync1 != r_db_level) begin
            if (r_db_cnt == CNT_LAST) begin
                r_db_level <= r_sync1;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_level = r_db_level;
`else
    // Without the filter the stable-cycle count has no effect; an illegal
    // value still shows up as a named block in the elaborated hierarchy.
    if (DEBOUNCE_CYCLES < 1) begin : g_illegal_debounce_cycles
    end

    assign w_level = r_sync1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_pulse = w_level & ~r_prev & r_armed;

endmodule

// File: rtl/event_counter_display.sv
// Up/down radix-BASE event counter with multiplexed 7-segment scan output.
// Define DEBOUNCE_EN to insert a DEBOUNCE_CYCLES stability filter on BTNC.
module event_counter_display
    import event_display_pkg::*;
#(
    parameter int N_DIGITS        = 4,
    parameter int BASE            = 10,
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  BTNC,
    input  logic                  dir,
    output logic [4*N_DIGITS-1:0] count,
    output logic [6:0]            segments,
    output logic [7:0]            anodos
);

    localparam logic [3:0] DIGIT_MAX = 4'(BASE - 1);
    localparam int SCAN_W = $clog2(REFRESH_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'(N_DIGITS - 1);

    genvar gi;

    logic                  w_event;
    logic [4*N_DIGITS-1:0] r_count;
    logic [4*N_DIGITS-1:0] w_count_next;
    logic [4*N_DIGITS-1:0] w_step_count;
    logic [N_DIGITS-1:0]   w_carry;
    logic [SCAN_W-1:0]     r_scan_cnt;
    logic [SCAN_W-1:0]     w_scan_next;
    logic [2:0]            r_idx;
    logic [2:0]            w_idx_next;
    logic [7:0]            r_anodos;
    logic [7:0]            w_anodos_next;
    logic [6:0]            r_segments;
    logic [6:0]            w_segments_next;
    logic [3:0]            w_nibbles [8];

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clock  (clock),
        .reset  (reset),
        .i_btn  (BTNC),
        .o_pulse(w_event)
    );

    // Ripple carry/borrow: a digit steps only when every lower digit wraps.
    assign w_carry[0] = 1'b1;

    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        logic [3:0] w_digit;
        logic       w_at_limit;
        logic [3:0] w_stepped;

        assign w_digit    = r_count[4*gi +: 4];
        assign w_at_limit = dir ? (w_digit == DIGIT_MAX) : (w_digit == 4'd0);

        always_comb begin
            w_stepped = w_digit;
            if (dir) begin
                w_stepped = w_at_limit ? 4'd0 : w_digit + 4'd1;
            end else begin
                w_stepped = w_at_limit ? DIGIT_MAX : w_digit - 4'd1;
            end
        end

        assign w_step_count[4*gi +: 4] = w_carry[gi] ? w_stepped : w_digit;

        if (gi < N_DIGITS - 1) begin : g_ripple
            assign w_carry[gi+1] = w_carry[gi] & w_at_limit;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = '0;
        end else if (w_event) begin
            w_count_next = w_step_count;
        end
    end

    always_comb begin
        w_scan_next = r_scan_cnt + 1'b1;
        w_idx_next  = r_idx;
        if (r_scan_cnt == SCAN_LAST) begin
            w_scan_next = '0;
            w_idx_next  = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end
    end

    // Display outputs are built from the next-state values so anode and
    // glyph move on the same edge as the index and the count.
    for (gi = 0; gi < 8; gi++) begin : g_anode
        if (gi < N_DIGITS) begin : g_active
            assign w_nibbles[gi]     = w_count_next[4*gi +: 4];
            assign w_anodos_next[gi] = (w_idx_next != 3'(gi));
        end else begin : g_unused
            assign w_nibbles[gi]     = 4'd0;
            assign w_anodos_next[gi] = 1'b1;
        end
    end

    always_comb begin
        w_segments_next = SEG_BLANK;
        if ({1'b0, w_idx_next} < 4'(N_DIGITS)) begin
            w_segments_next = glyph_of(w_nibbles[w_idx_next]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_scan_cnt <= '0;
            r_idx      <= 3'd0;
            r_anodos   <= 8'hFE;
            r_segments <= SEG_GLYPHS[0];
        end else begin
            r_count    <= w_count_next;
            r_scan_cnt <= w_scan_next;
            r_idx      <= w_idx_next;
            r_anodos   <= w_anodos_next;
            r_segments <= w_segments_next;
        end
    end

    assign count    = r_count;
    assign anodos   = r_anodos;
    assign segments = r_segments;

endmodule

// File: tb/tb_event_counter_display.sv
// Bench for event_counter_display: BCD and hex instances driven in parallel,
// checked every cycle against a value-level model plus literal expectations.
`timescale 1ns/1ps
module tb_event_counter_display;

    localparam int ND  = 4;
    localparam int RD  = 4;
    localparam int DBC = 8;
`ifdef DEBOUNCE_EN
    localparam int D_EFF  = DBC;
    localparam int EV_LAT = 3;
    localparam int HOLD   = 3 + DBC;
`else
    localparam int D_EFF  = 1;
    localparam int EV_LAT = 2;
    localparam int HOLD   = 3;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        BTNC  = 1'b0;
    logic        dir   = 1'b1;
    logic [15:0] count10, count16;
    logic [6:0]  seg10, seg16;
    logic [7:0]  an10, an16;

    event_counter_display #(.N_DIGITS(ND), .BASE(10), .REFRESH_DIV(RD), .DEBOUNCE_CYCLES(DBC)) dut10 (
        .clock(clock), .reset(reset), .clear(clear), .BTNC(BTNC), .dir(dir),
        .count(count10), .segments(seg10), .anodos(an10)
    );

    event_counter_display #(.N_DIGITS(ND), .BASE(16), .REFRESH_DIV(RD), .DEBOUNCE_CYCLES(DBC)) dut16 (
        .clock(clock), .reset(reset), .clear(clear), .BTNC(BTNC), .dir(dir),
        .count(count16), .segments(seg16), .anodos(an16)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [15:0] to_nibbles(input int v, input int base);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % base);
            t = t / base;
        end
        return r;
    endfunction

    // Model: integer counts modulo BASE^N, a run-length view of BTNC for
    // level acceptance, and a queue of edges at which accepted presses land.
    int m_n, m_val10, m_val16, m_F, m_run_val, m_run_len;
    bit m_low_seen, m_fire;
    int m_due [$];

    always @(posedge clock) begin
        if (reset) begin
            m_n = 0; m_val10 = 0; m_val16 = 0;
            m_F = 0; m_run_val = 0; m_run_len = 0; m_low_seen = 0;
            m_due.delete();
        end else begin
            m_n++;
            if (int'(BTNC) == m_run_val) m_run_len++;
            else begin m_run_val = int'(BTNC); m_run_len = 1; end
            if (m_run_val != m_F && m_run_len >= D_EFF) begin
                m_F = m_run_val;
                if (m_F == 1 && m_low_seen) m_due.push_back(m_n + EV_LAT);
            end
            if (!BTNC) m_low_seen = 1;
            m_fire = 0;
            if (m_due.size() > 0 && m_due[0] == m_n) begin
                void'(m_due.pop_front());
                m_fire = 1;
            end
            if (clear) begin
                m_val10 = 0; m_val16 = 0;
            end else if (m_fire) begin
                if (dir) begin
                    m_val10 = (m_val10 + 1) % 10000;
                    m_val16 = (m_val16 + 1) % 65536;
                end else begin
                    m_val10 = (m_val10 + 9999) % 10000;
                    m_val16 = (m_val16 + 65535) % 65536;
                end
            end
        end
    end

    always @(posedge clock) begin
        int idx;
        logic [15:0] e10, e16;
        logic [7:0]  ea;
        #1;
        idx = (m_n / RD) % ND;
        e10 = to_nibbles(m_val10, 10);
        e16 = to_nibbles(m_val16, 16);
        ea = 8'hFF;
        ea[idx] = 1'b0;
        check("count10", 32'(count10), 32'(e10));
        check("count16", 32'(count16), 32'(e16));
        check("anodos10", 32'(an10), 32'(ea));
        check("anodos16", 32'(an16), 32'(ea));
        check("segments10", 32'(seg10), 32'(glyph(4'((e10 >> (4*idx)) & 16'hF))));
        check("segments16", 32'(seg16), 32'(glyph(4'((e16 >> (4*idx)) & 16'hF))));
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clock);
    endtask

    task automatic press(input logic d);
        @(negedge clock);
        dir  = d;
        BTNC = 1'b1;
        cycles(HOLD);
        BTNC = 1'b0;
        cycles(HOLD);
    endtask

    logic [7:0] scan_exp [16];

    initial begin
        scan_exp = '{8'hFE, 8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFB,
                     8'hFB, 8'hFB, 8'hFB, 8'hF7, 8'hF7, 8'hF7, 8'hF7, 8'hFE};
        reset = 1'b1;
        cycles(3);
        check("reset_count", 32'(count10), 32'h0);
        check("reset_anodos", 32'(an10), 32'hFE);
        check("reset_segments", 32'(seg10), 32'h01);
        reset = 1'b0;

        for (int k = 0; k < 16; k++) begin
            @(posedge clock);
            #1;
            check("scan_literal", 32'(an10), 32'(scan_exp[k]));
        end

        for (int k = 0; k < 5; k++) press(1'b1);
        check("five_up_bcd", 32'(count10), 32'h0005);
        check("five_up_hex", 32'(count16), 32'h0005);

        @(negedge clock); clear = 1'b1;
        @(negedge clock); clear = 1'b0;
        check("clear_bcd", 32'(count10), 32'h0);

        press(1'b0);
        check("down_wrap_bcd", 32'(count10), 32'h9999);
        check("down_wrap_hex", 32'(count16), 32'hFFFF);
        press(1'b1);
        check("up_wrap_bcd", 32'(count10), 32'h0000);
        check("up_wrap_hex", 32'(count16), 32'h0000);

        press(1'b1);
        press(1'b1);
        @(negedge clock);
        dir  = 1'b1;
        BTNC = 1'b1;
        cycles(D_EFF - 1 + EV_LAT);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        cycles(HOLD);
        BTNC = 1'b0;
        cycles(HOLD);
        check("clear_beats_event_bcd", 32'(count10), 32'h0);
        check("clear_beats_event_hex", 32'(count16), 32'h0);

        for (int k = 0; k < 255; k++) press(1'b1);
        check("hex_00FF", 32'(count16), 32'h00FF);
        check("bcd_0255", 32'(count10), 32'h0255);
        press(1'b1);
        check("hex_carry_0100", 32'(count16), 32'h0100);
        check("bcd_0256", 32'(count10), 32'h0256);

`ifdef DEBOUNCE_EN
        @(negedge clock); BTNC = 1'b1;
        cycles(5);
        BTNC = 1'b0;
        cycles(12);
        check("glitch_ignored", 32'(count16), 32'h0100);
        BTNC = 1'b1;
        cycles(10);
        BTNC = 1'b0;
        cycles(12);
        check("long_press_once", 32'(count16), 32'h0101);
`endif

        @(negedge clock);
        BTNC  = 1'b1;
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(HOLD + 10);
        check("held_through_reset", 32'(count10), 32'h0);
        BTNC = 1'b0;
        cycles(HOLD);
        press(1'b1);
        check("press_after_release", 32'(count10), 32'h0001);

        cycles(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/event_counter_display.md
EVENT_COUNTER_DISPLAY -- requirements
Module: event_counter_display

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of active display digits, legal 1..8.
REQ-002 SHALL have parameter BASE, default 10, digit radix, legal values 10 (BCD) or 16 (hex).
REQ-003 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit in the display scan, legal >= 2.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, required stable cycles before a button level is accepted, legal >= 1.
REQ-005 SHALL use one clock and a synchronous, active-high reset, as listed in REQ-006 and REQ-007.
REQ-006 SHALL have port clock, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, synchronous active-high full reset.
REQ-008 SHALL have port clear, input, 1 bit, synchronous active-high clear of the count only.
REQ-009 SHALL have port BTNC, input, 1 bit, asynchronous event button; each accepted press is one count event.
REQ-010 SHALL have port dir, input, 1 bit, count direction: 1 = up, 0 = down; sampled when the event pulse fires.
REQ-011 SHALL have port count, output, 4*N_DIGITS bits, current count with one nibble per digit, digit 0 in the LSBs.
REQ-012 SHALL have port segments, output, 7 bits, {CA,CB,CC,CD,CE,CF,CG}, active-low.
REQ-013 SHALL have port anodos, output, 8 bits, {AN7..AN0}, active-low, at most one bit low at a time.

Function
REQ-014 SHALL pass BTNC through a 2-flop synchroniser, then a rising-edge detector that produces a 1-cycle event pulse.
REQ-015 SHALL raise count on the 2nd rising edge after BTNC is first sampled high (no debounce build); a held button produces exactly one event.
REQ-016 SHALL treat count as N_DIGITS cascaded radix-BASE digits; up from max (all digits BASE-1) wraps to 0; down from 0 wraps to max.
REQ-017 SHALL never hold a nibble value >= BASE in any digit.
REQ-018 SHALL give clear priority over an event in the same cycle: count becomes 0 and the event is discarded.
REQ-019 SHALL implement the scan counter as 0..REFRESH_DIV-1; at the terminal value the digit index advances 0..N_DIGITS-1 and then wraps to 0.
REQ-020 SHALL drive anodos with bit[idx] low and all other bits high; anodes >= N_DIGITS stay high permanently.
REQ-021 SHALL drive segments registered, in the same cycle as anodos, with the 0-F glyph of the selected digit.
REQ-022 SHALL leave clear free of effect on the scan counter and digit index.

Reset
REQ-023 SHALL on reset set count=0, scan counter=0, idx=0, synchroniser and edge flops=0, anodos=8'hFE and segments=7'b0000001 (glyph "0").
REQ-024 SHALL let reset override clear and events; a press held through the release of reset SHALL NOT produce an event until BTNC has been seen low.

Configuration
REQ-025 SHALL, when DEBOUNCE_EN is defined, accept a synchronised level change only after it is stable for DEBOUNCE_CYCLES consecutive cycles, adding DEBOUNCE_CYCLES cycles of latency.
REQ-026 SHALL, when DEBOUNCE_EN is undefined, use synchroniser plus edge detector only, with the REQ-015 latency.

Structure
REQ-027 SHALL place the 7-segment glyph typedef, the 16-entry glyph constant table and SEG_BLANK in package event_display_pkg.
REQ-028 SHALL implement synchroniser, optional debounce and edge detector in sub-module btn_conditioner.

Verification
REQ-029 SHALL cover: reset, then BTNC pulsed 5 times (each high 3 cycles) with dir=1 -> count=16'h0005.
REQ-030 SHALL cover: BASE=10, count=16'h9999, one up event -> 16'h0000; one down event from 0 -> 16'h9999.
REQ-031 SHALL cover: BASE=16, count=16'h00FF, one up event -> 16'h0100.
REQ-032 SHALL cover: clear and an event pulse in the same cycle -> count=0 and the scan index is undisturbed.
REQ-033 SHALL cover: REFRESH_DIV=4, N_DIGITS=4 -> anodos cycles FE,FD,FB,F7,FE with 4 cycles each; segments match the digit nibble.
REQ-034 SHALL cover: DEBOUNCE_EN with DEBOUNCE_CYCLES=8; BTNC glitch of 5 cycles -> no event; 10 cycles high -> exactly one event.
